// File: rtl/id_ex_reg.sv
// ID/EX pipeline register: carries decoded control and operand data from decode into execute.
// Control fields are squashed to a bubble on flush, failed condition or an illegal load/store mix.
module id_ex_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        flush,
  input  logic        cond_pass,
  input  logic [3:0]  exe_cmd_in,
  input  logic        mem_r_in,
  input  logic        mem_w_in,
  input  logic        wb_en_in,
  input  logic        b_in,
  input  logic        s_in,
  input  logic [31:0] pc_in,
  input  logic [31:0] val_rn_in,
  input  logic [31:0] val_rm_in,
  input  logic        imm_in,
  input  logic [11:0] shift_op_in,
  input  logic [23:0] simm24_in,
  input  logic [3:0]  dest_in,
  input  logic [3:0]  src1_in,
  input  logic [3:0]  src2_in,
  input  logic [3:0]  sr_in,
  output logic [3:0]  exe_cmd,
  output logic        mem_r,
  output logic        mem_w,
  output logic        wb_en,
  output logic        b,
  output logic        s,
  output logic [31:0] pc,
  output logic [31:0] val_rn,
  output logic [31:0] val_rm,
  output logic        imm,
  output logic [11:0] shift_op,
  output logic [23:0] simm24,
  output logic [3:0]  dest,
  output logic [3:0]  src1,
  output logic [3:0]  src2,
  output logic        c_in,
  output logic        valid
);

  logic load_en;
  logic issue;

  // Flush overrides freeze so a taken branch always kills the instruction in ID.
  always_comb begin
    load_en = flush | ~freeze;
    issue   = ~flush & cond_pass & ~(mem_r_in & mem_w_in);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc       <= '0;
      val_rn   <= '0;
      val_rm   <= '0;
      imm      <= 1'b0;
      shift_op <= '0;
      simm24   <= '0;
      dest     <= '0;
      src1     <= '0;
      src2     <= '0;
      c_in     <= 1'b0;
    end else if (load_en) begin
      pc       <= pc_in;
      val_rn   <= val_rn_in;
      val_rm   <= val_rm_in;
      imm      <= imm_in;
      shift_op <= shift_op_in;
      simm24   <= simm24_in;
      dest     <= dest_in;
      src1     <= src1_in;
      src2     <= src2_in;
      c_in     <= sr_in[1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      exe_cmd <= '0;
      mem_r   <= 1'b0;
      mem_w   <= 1'b0;
      wb_en   <= 1'b0;
      b       <= 1'b0;
      s       <= 1'b0;
      valid   <= 1'b0;
    end else if (load_en) begin
      if (issue) begin
        exe_cmd <= exe_cmd_in;
        mem_r   <= mem_r_in;
        mem_w   <= mem_w_in;
        wb_en   <= wb_en_in;
        b       <= b_in;
        s       <= s_in;
        valid   <= 1'b1;
      end else begin
        exe_cmd <= '0;
        mem_r   <= 1'b0;
        mem_w   <= 1'b0;
        wb_en   <= 1'b0;
        b       <= 1'b0;
        s       <= 1'b0;
        valid   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_id_ex_reg.sv
// Scoreboard bench for id_ex_reg: directed scenarios plus randomized traffic against a
// behavioural model of the stage; a monitor pops expected outputs one cycle after issue.
module tb_id_ex_reg;

  typedef struct packed {
    logic        freeze;
    logic        flush;
    logic        cond_pass;
    logic [3:0]  exe_cmd;
    logic        mem_r;
    logic        mem_w;
    logic        wb_en;
    logic        b;
    logic        s;
    logic [31:0] pc;
    logic [31:0] val_rn;
    logic [31:0] val_rm;
    logic        imm;
    logic [11:0] shift_op;
    logic [23:0] simm24;
    logic [3:0]  dest;
    logic [3:0]  src1;
    logic [3:0]  src2;
    logic [3:0]  sr;
  } in_t;

  typedef struct packed {
    logic [3:0]  exe_cmd;
    logic        mem_r;
    logic        mem_w;
    logic        wb_en;
    logic        b;
    logic        s;
    logic [31:0] pc;
    logic [31:0] val_rn;
    logic [31:0] val_rm;
    logic        imm;
    logic [11:0] shift_op;
    logic [23:0] simm24;
    logic [3:0]  dest;
    logic [3:0]  src1;
    logic [3:0]  src2;
    logic        c_in;
    logic        valid;
  } out_t;

  logic clk;
  logic rst;
  in_t  vin;
  out_t act;
  out_t mstate;
  out_t expq[$];
  int   n_tests;
  int   n_fail;

  logic [3:0]  exe_cmd;
  logic        mem_r, mem_w, wb_en, b, s, imm, c_in, valid;
  logic [31:0] pc, val_rn, val_rm;
  logic [11:0] shift_op;
  logic [23:0] simm24;
  logic [3:0]  dest, src1, src2;

  id_ex_reg dut (
    .clk        (clk),
    .rst        (rst),
    .freeze     (vin.freeze),
    .flush      (vin.flush),
    .cond_pass  (vin.cond_pass),
    .exe_cmd_in (vin.exe_cmd),
    .mem_r_in   (vin.mem_r),
    .mem_w_in   (vin.mem_w),
    .wb_en_in   (vin.wb_en),
    .b_in       (vin.b),
    .s_in       (vin.s),
    .pc_in      (vin.pc),
    .val_rn_in  (vin.val_rn),
    .val_rm_in  (vin.val_rm),
    .imm_in     (vin.imm),
    .shift_op_in(vin.shift_op),
    .simm24_in  (vin.simm24),
    .dest_in    (vin.dest),
    .src1_in    (vin.src1),
    .src2_in    (vin.src2),
    .sr_in      (vin.sr),
    .exe_cmd    (exe_cmd),
    .mem_r      (mem_r),
    .mem_w      (mem_w),
    .wb_en      (wb_en),
    .b          (b),
    .s          (s),
    .pc         (pc),
    .val_rn     (val_rn),
    .val_rm     (val_rm),
    .imm        (imm),
    .shift_op   (shift_op),
    .simm24     (simm24),
    .dest       (dest),
    .src1       (src1),
    .src2       (src2),
    .c_in       (c_in),
    .valid      (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb act = {exe_cmd, mem_r, mem_w, wb_en, b, s, pc, val_rn, val_rm, imm, shift_op,
                     simm24, dest, src1, src2, c_in, valid};

  // What the EXE stage should see after one edge, stated as instruction-level rules.
  function automatic out_t model(out_t cur, in_t i, logic rst_now);
    out_t n;
    logic live;
    if (!rst_now) return '0;
    if (i.freeze && !i.flush) return cur;
    n          = '0;
    n.pc       = i.pc;
    n.val_rn   = i.val_rn;
    n.val_rm   = i.val_rm;
    n.imm      = i.imm;
    n.shift_op = i.shift_op;
    n.simm24   = i.simm24;
    n.dest     = i.dest;
    n.src1     = i.src1;
    n.src2     = i.src2;
    n.c_in     = i.sr[1];
    live = !i.flush && i.cond_pass && !(i.mem_r && i.mem_w);
    if (live) begin
      n.exe_cmd = i.exe_cmd;
      n.mem_r   = i.mem_r;
      n.mem_w   = i.mem_w;
      n.wb_en   = i.wb_en;
      n.b       = i.b;
      n.s       = i.s;
      n.valid   = 1'b1;
    end
    return n;
  endfunction

  function automatic in_t rand_in();
    in_t r;
    r.freeze    = ($urandom_range(0, 3) == 0);
    r.flush     = ($urandom_range(0, 6) == 0);
    r.cond_pass = ($urandom_range(0, 4) != 0);
    r.exe_cmd   = 4'($urandom);
    r.mem_r     = 1'($urandom);
    r.mem_w     = 1'($urandom);
    r.wb_en     = 1'($urandom);
    r.b         = 1'($urandom);
    r.s         = 1'($urandom);
    r.pc        = $urandom;
    r.val_rn    = $urandom;
    r.val_rm    = $urandom;
    r.imm       = 1'($urandom);
    r.shift_op  = 12'($urandom);
    r.simm24    = 24'($urandom);
    r.dest      = 4'($urandom);
    r.src1      = 4'($urandom);
    r.src2      = 4'($urandom);
    r.sr        = 4'($urandom);
    return r;
  endfunction

  task automatic chk(input string name, input logic [159:0] got, input logic [159:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  // Drive one set of ID-stage inputs and queue the expected EXE-stage state.
  task automatic step(input in_t v);
    @(negedge clk);
    vin    = v;
    mstate = model(mstate, v, rst);
    expq.push_back(mstate);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic async_reset_pulse();
    #1;
    rst = 1'b0;
    #1;
    mstate = '0;
    chk("async_reset_clears", 160'(act), 160'(0));
  endtask

  // Monitor: one registered result per edge.
  always begin
    out_t e;
    @(posedge clk);
    #1;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      chk("scoreboard", 160'(act), 160'(e));
    end
  end

  initial begin
    in_t add_i;
    in_t v;
    n_tests = 0;
    n_fail  = 0;
    mstate  = '0;
    rst     = 1'b0;
    vin     = '0;
    #2;
    chk("reset_state", 160'(act), 160'(0));
    step(rand_in());
    step(rand_in());
    settle();
    rst = 1'b1;

    // Basic ALU instruction load
    add_i           = '0;
    add_i.cond_pass = 1'b1;
    add_i.exe_cmd   = 4'b0010;
    add_i.wb_en     = 1'b1;
    add_i.dest      = 4'd3;
    add_i.val_rn    = 32'h5;
    add_i.sr        = 4'b0010;
    step(add_i);
    settle();
    chk("load_exe_cmd", 160'(exe_cmd), 160'(4'b0010));
    chk("load_dest", 160'(dest), 160'(3));
    chk("load_val_rn", 160'(val_rn), 160'(5));
    chk("load_c_in", 160'(c_in), 160'(1));
    chk("load_valid", 160'({wb_en, valid}), 160'(2'b11));

    // Three frozen cycles hold the ADD, then the waiting instruction loads
    v         = add_i;
    v.exe_cmd = 4'b0100;
    v.freeze  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step(v);
      settle();
      chk("freeze_hold", 160'({exe_cmd, valid}), 160'({4'b0010, 1'b1}));
    end
    v.freeze = 1'b0;
    step(v);
    settle();
    chk("unfreeze_load", 160'(exe_cmd), 160'(4'b0100));

    // Flush beats freeze; data still passes through
    v        = add_i;
    v.flush  = 1'b1;
    v.freeze = 1'b1;
    v.mem_w  = 1'b1;
    v.pc     = 32'h20;
    step(v);
    settle();
    chk("flush_bubble", 160'({mem_w, wb_en, valid}), 160'(0));
    chk("flush_pc", 160'(pc), 160'(32'h20));
    v.freeze = 1'b0;
    v.pc     = 32'h24;
    step(v);
    settle();
    chk("flush_twice", 160'({valid, pc}), 160'({1'b0, 32'h24}));

    // Flush arriving on the cycle freeze drops
    step(add_i);
    v        = add_i;
    v.freeze = 1'b1;
    step(v);
    v.freeze = 1'b0;
    v.flush  = 1'b1;
    step(v);
    settle();
    chk("flush_after_freeze", 160'(valid), 160'(0));

    // Condition failed
    v           = add_i;
    v.cond_pass = 1'b0;
    v.mem_r     = 1'b1;
    v.dest      = 4'd7;
    step(v);
    settle();
    chk("cond_fail", 160'({wb_en, mem_r, valid, dest}), 160'({3'b000, 4'd7}));

    // Load and store together is rejected
    v           = add_i;
    v.mem_r     = 1'b1;
    v.mem_w     = 1'b1;
    step(v);
    settle();
    chk("illegal_mem", 160'({mem_r, mem_w, valid}), 160'(0));

    // Branch with writeback passes through
    v       = add_i;
    v.b     = 1'b1;
    v.wb_en = 1'b1;
    step(v);
    settle();
    chk("branch_link", 160'({b, wb_en, valid}), 160'(3'b111));

    // Reset between edges, held across an edge
    async_reset_pulse();
    step(add_i);
    settle();
    rst = 1'b1;

    // Reset in the middle of a freeze discards the held instruction
    step(add_i);
    v        = add_i;
    v.freeze = 1'b1;
    step(v);
    settle();
    async_reset_pulse();
    rst = 1'b1;
    step(v);
    settle();
    chk("reset_mid_freeze", 160'(valid), 160'(0));
    step(add_i);
    settle();
    chk("load_after_reset", 160'(valid), 160'(1));

    // Randomized traffic with occasional asynchronous resets
    for (int k = 0; k < 600; k++) begin
      step(rand_in());
      if ($urandom_range(0, 59) == 0) begin
        settle();
        async_reset_pulse();
        step(rand_in());
        settle();
        rst = 1'b1;
      end
    end
    settle();
    settle();
    chk("queue_drained", 160'(expq.size()), 160'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ex_reg.md
ID_EX_REG -- requirements
Module: id_ex_reg

Interface
REQ-001 clk  input  1  rising-edge clock for all state.
REQ-002 rst  input  1  asynchronous, active-low reset; 0 clears all state immediately.
REQ-003 freeze  input  1  hold all registered outputs (hazard stall).
REQ-004 flush  input  1  insert bubble (branch taken in EXE).
REQ-005 cond_pass  input  1  condition-check result for the instruction in ID.
REQ-006 exe_cmd_in  input  4  ALU command from the control unit.
REQ-007 mem_r_in, mem_w_in, wb_en_in, b_in, s_in  input  1 each  control-unit outputs.
REQ-008 pc_in  input  32  PC+4 of the ID instruction.
REQ-009 val_rn_in, val_rm_in  input  32 each  register-file read data.
REQ-010 imm_in  input  1  immediate-operand flag.
REQ-011 shift_op_in  input  12  shifter operand field.
REQ-012 simm24_in  input  24  signed branch offset.
REQ-013 dest_in, src1_in, src2_in  input  4 each  destination and source register numbers.
REQ-014 sr_in  input  4  current NZCV; only C is consumed downstream.
REQ-015 Outputs: exe_cmd, mem_r, mem_w, wb_en, b, s, pc, val_rn, val_rm, imm, shift_op, simm24, dest, src1, src2, c_in; widths match their inputs (c_in = 1 bit).
REQ-016 valid  output  1  stage holds a real instruction.

Function
REQ-017 All outputs SHALL be registered and update only on the rising clk edge; latency ID to EXE is exactly 1 cycle.
REQ-018 Control group = {exe_cmd, mem_r, mem_w, wb_en, b, s, valid}; data group = all other outputs.
REQ-019 Edge priority SHALL be: flush > freeze > normal load.
REQ-020 flush=1: control group loads 0 (bubble); data group loads its inputs; freeze ignored.
REQ-021 flush=0, freeze=1: every output holds its current value, valid included.
REQ-022 Normal load, cond_pass=1: all outputs load their inputs; valid loads 1; c_in loads sr_in[1] (C bit, NZCV order [3:0]=N,Z,C,V).
REQ-023 Normal load, cond_pass=0: control group loads 0 (instruction squashed); data group loads its inputs.
REQ-024 mem_r and mem_w SHALL never both be 1 at the outputs; if both inputs are 1 with cond_pass=1, both outputs load 0 and valid loads 0.
REQ-025 b=1 with wb_en=1 is legal and passed unchanged.
REQ-026 No combinational path from any input to any output.
REQ-027 Consecutive flushes produce consecutive bubbles; a flush on the cycle freeze deasserts still yields a bubble.

Reset
REQ-028 rst=0 SHALL clear every output to 0 asynchronously, independent of clk, freeze and flush.
REQ-029 After rst rises, the first clk edge performs a normal load per REQ-019..REQ-024.
REQ-030 Reset asserted mid-freeze discards the held instruction; valid=0 after release until the next load.

Verification
REQ-031 Normal load: exe_cmd_in=0010, wb_en_in=1, dest_in=3, val_rn_in=0x0000_0005, sr_in=0010, cond_pass=1 -> next edge exe_cmd=0010, wb_en=1, dest=3, val_rn=5, c_in=1, valid=1.
REQ-032 Freeze: load ADD as above, then freeze=1 for 3 cycles with exe_cmd_in=0100 -> outputs stay exe_cmd=0010, valid=1; first edge after freeze=0 loads 0100.
REQ-033 Flush priority: flush=1 and freeze=1 with mem_w_in=1, pc_in=0x20 -> next edge mem_w=0, wb_en=0, valid=0, pc=0x20.
REQ-034 Condition fail: cond_pass=0, wb_en_in=1, mem_r_in=1, dest_in=7 -> next edge wb_en=0, mem_r=0, valid=0, dest=7.
REQ-035 Async reset: with valid=1, pull rst low between edges -> all outputs 0 before next clk edge; hold rst low across edges -> still 0.
REQ-036 Illegal mem: mem_r_in=1, mem_w_in=1, cond_pass=1 -> next edge mem_r=0, mem_w=0, valid=0.
